dmem_arbiter: RTL and testbench

- Shares the single-port 1K x 32 data memory between two requesters: port 0 (CPU MEM stage) and port 1 (debug/DMA loader).
- Sits between the requesters and the data memory and drives the memory's data_in, ADDR and WR_RD inputs.
- Provides a per-port request/grant/valid handshake, round-robin arbitration and optional locked bursts.
- The memory returns read data one clock after address/WR_RD are presented; the arbiter tags each issued access so the response is returned to its owner.

---
 rtl/dmem_arbiter.sv | 153 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: round-robin with locked bursts,
// 1-cycle tagged responses. Define DMEM_ARB_PRIO0_EN for fixed port-0 priority.
module dmem_arbiter #(
  parameter int AW        = 10,
  parameter int DW        = 32,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          valid0,
  output logic          valid1,
  output logic [DW-1:0] rdata,
  output logic [DW-1:0] mem_data_in,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_rd,
  input  logic [DW-1:0] mem_data_out
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  typedef struct packed {
    logic          we;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_t;

  localparam bit       LOCK_OK = (MAX_BURST > 1);
  localparam logic [8:0] MB    = 9'(MAX_BURST);

  state_t     state, state_n;
  logic       rr_last, rr_n;
  logic [7:0] burst_cnt, cnt_n;
  logic [8:0] cnt_inc;
  logic [1:0] resp_tag;
  logic [1:0] gnt_raw, gnt;
  logic       own;
  acc_t       acc [2];
  acc_t       sel;

  assign acc[0]  = '{we: we0, lock: lock0, addr: addr0, wdata: wdata0};
  assign acc[1]  = '{we: we1, lock: lock1, addr: addr1, wdata: wdata1};
  assign cnt_inc = {1'b0, burst_cnt} + 9'd1;

  // Grant selection; a held request during reset must never reach the memory.
  always_comb begin
    gnt_raw = 2'b00;
    own     = 1'b0;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
`ifdef DMEM_ARB_PRIO0_EN
          own = 1'b0;
`else
          own = ~rr_last;
`endif
          gnt_raw[own] = 1'b1;
        end else if (req0) begin
          own        = 1'b0;
          gnt_raw[0] = 1'b1;
        end else if (req1) begin
          own        = 1'b1;
          gnt_raw[1] = 1'b1;
        end
      end
      LOCK0: begin
        own        = 1'b0;
        gnt_raw[0] = req0;
      end
      LOCK1: begin
        own        = 1'b1;
        gnt_raw[1] = req1;
      end
      default: ;
    endcase
    gnt = rst ? 2'b00 : gnt_raw;
  end

  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];
  assign sel  = acc[own];

  always_comb begin
    state_n = state;
    rr_n    = rr_last;
    cnt_n   = burst_cnt;
    case (state)
      IDLE: begin
        if (|gnt_raw) begin
          rr_n = own;
          if (sel.lock && LOCK_OK) begin
            state_n = own ? LOCK1 : LOCK0;
            cnt_n   = 8'd1;
          end
        end
      end
      LOCK0, LOCK1: begin
        if (|gnt_raw && sel.lock && (cnt_inc < MB)) begin
          cnt_n = cnt_inc[7:0];
        end else begin
          // Lock dropped, burst limit hit, or owner went away: hand back to arbitration.
          state_n = IDLE;
          rr_n    = own;
          cnt_n   = 8'd0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_last   <= 1'b1;
      burst_cnt <= 8'd0;
      resp_tag  <= 2'b00;
    end else begin
      state     <= state_n;
      rr_last   <= rr_n;
      burst_cnt <= cnt_n;
      resp_tag  <= gnt;
    end
  end

  // Idle bus parks as a read of word 0 so the memory is never written spuriously.
  always_comb begin
    mem_addr    = '0;
    mem_data_in = '0;
    mem_wr_rd   = 1'b1;
    if (|gnt) begin
      mem_addr    = sel.addr;
      mem_data_in = sel.wdata;
      mem_wr_rd   = ~sel.we;
    end
  end

  assign valid0 = resp_tag[0];
  assign valid1 = resp_tag[1];
  assign rdata  = mem_data_out;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1K x 32 synchronous memory.
module tb_dmem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, valid0, valid1;
  logic [DW-1:0] rdata, mem_data_in, mem_data_out;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_rd;
  logic [DW-1:0] mem [0:1023];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .valid0(valid0), .valid1(valid1),
    .rdata(rdata), .mem_data_in(mem_data_in), .mem_addr(mem_addr),
    .mem_wr_rd(mem_wr_rd), .mem_data_out(mem_data_out)
  );

  always @(posedge clk) begin
    if (!mem_wr_rd) mem[mem_addr] <= mem_data_in;
    mem_data_out <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs on the falling edge, then let combinational outputs settle.
  task automatic drive(input logic r0, input logic w0, input logic l0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input logic r1, input logic w1, input logic l1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    @(negedge clk);
    req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i);
    mem_data_out = '0;
    rst = 1'b1;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b0; lock0 = 1'b1; lock1 = 1'b0;
    addr0 = 10'd9; addr1 = 10'd4; wdata0 = 32'h1234; wdata1 = 32'h0;
    #2;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_valid0", valid0, 0);
    chk("rst_valid1", valid1, 0);
    chk("rst_wr_rd", mem_wr_rd, 1);
    chk("rst_addr", mem_addr, 0);
    chk("rst_din", mem_data_in, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single read of word 5
    drive(1, 0, 0, 5, 0, 0, 0, 0, 0, 0);
    chk("rd5_gnt0", gnt0, 1);
    chk("rd5_gnt1", gnt1, 0);
    chk("rd5_addr", mem_addr, 5);
    chk("rd5_wr_rd", mem_wr_rd, 1);
    idle();
    chk("rd5_valid0", valid0, 1);
    chk("rd5_rdata", rdata, 32'h5);
    chk("rd5_gnt0_off", gnt0, 0);
    chk("rd5_wr_rd_idle", mem_wr_rd, 1);

    // Write then read back address 3
    drive(1, 1, 0, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    chk("wr3_valid0_prev", valid0, 0);
    chk("wr3_gnt0", gnt0, 1);
    chk("wr3_wr_rd", mem_wr_rd, 0);
    chk("wr3_din", mem_data_in, 32'hDEADBEEF);
    drive(1, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    chk("rd3_wr_rd", mem_wr_rd, 1);
    chk("wr3_ack", valid0, 1);
    idle();
    chk("rd3_valid0", valid0, 1);
    chk("rd3_rdata", rdata, 32'hDEADBEEF);
    idle();
    chk("rd3_valid0_end", valid0, 0);

    // Port 1 alone, leaves rr_last = 1 so port 0 wins the next contention
    drive(0, 0, 0, 0, 0, 1, 0, 0, 7, 0);
    chk("p1_gnt1", gnt1, 1);
    chk("p1_gnt0", gnt0, 0);
    idle();
    chk("p1_valid1", valid1, 1);
    chk("p1_valid0", valid0, 0);
    chk("p1_rdata", rdata, 32'h7);

`ifndef DMEM_ARB_PRIO0_EN
    // Round-robin: both ports held, no lock
    for (int k = 0; k < 6; k++) begin
      drive(1, 0, 0, 10, 0, 1, 0, 0, 20, 0);
      chk($sformatf("rr%0d_gnt0", k), gnt0, (k % 2 == 0));
      chk($sformatf("rr%0d_gnt1", k), gnt1, (k % 2 == 1));
      if (k > 0) begin
        chk($sformatf("rr%0d_valid0", k), valid0, (k % 2 == 1));
        chk($sformatf("rr%0d_valid1", k), valid1, (k % 2 == 0));
        chk($sformatf("rr%0d_rdata", k), rdata, (k % 2 == 1) ? 32'd10 : 32'd20);
      end
    end
    idle();
    chk("rr_last_valid1", valid1, 1);
    chk("rr_last_valid0", valid0, 0);
`else
    // Fixed priority: port 0 wins every contention
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 0, 10, 0, 1, 0, 0, 20, 0);
      chk($sformatf("pr%0d_gnt0", k), gnt0, 1);
      chk($sformatf("pr%0d_gnt1", k), gnt1, 0);
    end
    drive(0, 0, 0, 0, 0, 1, 0, 0, 20, 0);
    chk("pr_drop_gnt1", gnt1, 1);
    chk("pr_drop_valid0", valid0, 1);
    idle();
`endif

    // Locked burst on port 1 with MAX_BURST = 4 while port 0 waits
    drive(0, 0, 0, 0, 0, 1, 0, 1, 30, 0);
    chk("lk0_gnt1", gnt1, 1);
    for (int k = 1; k < 4; k++) begin
      drive(1, 0, 0, 11, 0, 1, 0, 1, 30, 0);
      chk($sformatf("lk%0d_gnt1", k), gnt1, 1);
      chk($sformatf("lk%0d_gnt0", k), gnt0, 0);
      chk($sformatf("lk%0d_valid1", k), valid1, 1);
    end
    drive(1, 0, 0, 11, 0, 1, 0, 1, 30, 0);
    chk("lk_end_gnt0", gnt0, 1);
    chk("lk_end_gnt1", gnt1, 0);
    chk("lk_end_addr", mem_addr, 11);
    idle();
    chk("lk_end_valid0", valid0, 1);
    chk("lk_end_rdata", rdata, 32'd11);

    // Reset in the cycle after a read grant discards the response
    drive(1, 0, 0, 5, 0, 0, 0, 0, 0, 0);
    chk("mr_gnt0", gnt0, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mr_valid0", valid0, 0);
    chk("mr_gnt0_rst", gnt0, 0);
    chk("mr_wr_rd", mem_wr_rd, 1);
    chk("mr_addr", mem_addr, 0);
    chk("mr_din", mem_data_in, 0);
    @(negedge clk);
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    addr0 = 10'd6; addr1 = 10'd8;
    #1;
    chk("mr_rel_valid0", valid0, 0);
    chk("mr_rel_gnt0", gnt0, 1);
    chk("mr_rel_gnt1", gnt1, 0);
    idle();
    chk("mr_rel_resp", valid0, 1);
    chk("mr_rel_rdata", rdata, 32'd6);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
